// File: rtl/rv_decode_pkg.sv
// Shared types and constants for the RISC-V decode stage: opcode map,
// funct3/funct7/funct12 values, decoded-entry layouts and immediate extraction.
package rv_decode_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'h03,
        OPC_FENCE  = 7'h0F,
        OPC_IMM    = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_IMM_32 = 7'h1B,
        OPC_STORE  = 7'h23,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37,
        OPC_OP_32  = 7'h3B,
        OPC_BRANCH = 7'h63,
        OPC_JALR   = 7'h67,
        OPC_JAL    = 7'h6F,
        OPC_SYSTEM = 7'h73
    } opcode_e;

    localparam logic [6:0]  F7_BASE      = 7'h00;
    localparam logic [6:0]  F7_ALT       = 7'h20;

    localparam logic [2:0]  F3_ADD_SUB   = 3'd0;
    localparam logic [2:0]  F3_SLL       = 3'd1;
    localparam logic [2:0]  F3_SRL_SRA   = 3'd5;

    localparam logic [2:0]  F3_SW        = 3'd2;
    localparam logic [2:0]  F3_LD        = 3'd3;
    localparam logic [2:0]  F3_SD        = 3'd3;
    localparam logic [2:0]  F3_LWU       = 3'd6;
    localparam logic [2:0]  F3_LD_RSVD   = 3'd7;

    localparam logic [2:0]  F3_BR_RSVD_A = 3'd2;
    localparam logic [2:0]  F3_BR_RSVD_B = 3'd3;
    localparam logic [2:0]  F3_JALR      = 3'd0;

    localparam logic [2:0]  F3_PRIV      = 3'd0;
    localparam logic [2:0]  F3_SYS_RSVD  = 3'd4;

    localparam logic [11:0] F12_ECALL    = 12'h000;
    localparam logic [11:0] F12_EBREAK   = 12'h001;

    // Width-independent part of a decoded entry.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] funct12;
        logic        decode_error;
        logic        is_ecall;
        logic        is_ebreak;
        logic        is_csr;
    } dec_fields_t;

    typedef struct packed {
        dec_fields_t f;
        logic [31:0] imm;
    } dec_entry32_t;

    typedef struct packed {
        dec_fields_t f;
        logic [63:0] imm;
    } dec_entry64_t;

    // Format-selected immediate, sign-extended to 64 bits; callers truncate to XLEN.
    function automatic logic [63:0] imm_extract(input logic [31:0] inst);
        logic [63:0] sx;
        logic [63:0] imm;
        sx = {64{inst[31]}};
        case (inst[6:0])
            OPC_STORE:          imm = {sx[63:12], inst[31:25], inst[11:7]};
            OPC_LUI, OPC_AUIPC: imm = {sx[63:32], inst[31:12], 12'b0};
            OPC_JAL:            imm = {sx[63:21], inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            OPC_BRANCH:         imm = {sx[63:13], inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            default:            imm = {sx[63:12], inst[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_decode_fifo.sv
// Generic valid/ready FIFO with synchronous flush. in_ready depends only on
// the fill level, so downstream back-pressure never reaches the producer
// combinationally. Data outputs read as zero while empty.
module rv_decode_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    // Next pointer/count; flush empties the queue but a same-cycle pop is still a transfer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    // Control state, reset to empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are only observed through a valid read pointer.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/rv_decode_stage.sv
// RISC-V decode stage: decodes each accepted instruction combinationally and
// queues the result (fields, immediate, legality and SYSTEM classification)
// in an output FIFO. Illegal instructions are queued in order like any other.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int PC_WIDTH     = 32,
    parameter int BUFFER_DEPTH = 2,
    parameter int ENABLE_ZICSR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [6:0]          out_opcode,
    output logic [4:0]          out_rd,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [2:0]          out_funct3,
    output logic [6:0]          out_funct7,
    output logic [11:0]         out_funct12,
    output logic [XLEN-1:0]     out_imm,
    output logic                out_decode_error,
    output logic                out_is_ecall,
    output logic                out_is_ebreak,
    output logic                out_is_csr
);

    localparam int FIELDS_W  = $bits(dec_fields_t);
    localparam int PAYLOAD_W = PC_WIDTH + XLEN + FIELDS_W;

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] f12;
    logic        dec_err;
    logic        is_sys;
    dec_fields_t f_in, f_out;
    logic [XLEN-1:0]      imm_in;
    logic [PAYLOAD_W-1:0] fifo_din, fifo_dout;

    assign opc    = in_inst[6:0];
    assign rd     = in_inst[11:7];
    assign f3     = in_inst[14:12];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign f7     = in_inst[31:25];
    assign f12    = in_inst[31:20];
    assign is_sys = (opc == OPC_SYSTEM);
    assign imm_in = XLEN'(imm_extract(in_inst));

    // Legality check per opcode; RV64-only encodings are rejected when XLEN=32.
    always_comb begin
        dec_err = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE: dec_err = 1'b0;
            OPC_OP: begin
                dec_err = !((f7 == F7_BASE) ||
                            ((f7 == F7_ALT) && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)));
            end
            OPC_IMM: begin
                if (f3 == F3_SLL || f3 == F3_SRL_SRA) begin
                    // RV64 shamt takes inst[25], so only inst[31:26] carries the shift type.
                    if (XLEN == 64)
                        dec_err = !(in_inst[31:26] == 6'h00 || in_inst[31:26] == 6'h10);
                    else
                        dec_err = !(f7 == F7_BASE || f7 == F7_ALT);
                    if (f3 == F3_SLL && in_inst[30]) dec_err = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (XLEN == 64) dec_err = (f3 == F3_LD_RSVD);
                else            dec_err = (f3 == F3_LD || f3 == F3_LWU || f3 == F3_LD_RSVD);
            end
            OPC_STORE: begin
                if (XLEN == 64) dec_err = (f3 > F3_SD);
                else            dec_err = (f3 > F3_SW);
            end
            OPC_BRANCH: dec_err = (f3 == F3_BR_RSVD_A || f3 == F3_BR_RSVD_B);
            OPC_JALR:   dec_err = (f3 != F3_JALR);
            OPC_SYSTEM: begin
                if (f3 == F3_PRIV)
                    dec_err = !((f12 == F12_ECALL || f12 == F12_EBREAK) &&
                                rd == '0 && rs1 == '0);
                else if (f3 == F3_SYS_RSVD)
                    dec_err = 1'b1;
                else
                    dec_err = (ENABLE_ZICSR == 0);
            end
            OPC_OP_32, OPC_IMM_32: dec_err = (XLEN != 64);
            default: dec_err = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11) dec_err = 1'b1;
    end

    // Assemble the decoded fields; classification flags are suppressed on illegal encodings.
    always_comb begin
        f_in.opcode       = opc;
        f_in.rd           = rd;
        f_in.rs1          = rs1;
        f_in.rs2          = rs2;
        f_in.funct3       = f3;
        f_in.funct7       = f7;
        f_in.funct12      = f12;
        f_in.decode_error = dec_err;
        f_in.is_ecall     = !dec_err && is_sys && (f3 == F3_PRIV) && (f12 == F12_ECALL);
        f_in.is_ebreak    = !dec_err && is_sys && (f3 == F3_PRIV) && (f12 == F12_EBREAK);
        f_in.is_csr       = !dec_err && is_sys && (f3 != F3_PRIV) && (f3 != F3_SYS_RSVD) &&
                            (ENABLE_ZICSR != 0);
    end

    assign fifo_din = {in_pc, imm_in, f_in};

    rv_decode_fifo #(
        .DEPTH (BUFFER_DEPTH),
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (fifo_din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_dout)
    );

    assign out_pc  = fifo_dout[PAYLOAD_W-1 -: PC_WIDTH];
    assign out_imm = fifo_dout[FIELDS_W +: XLEN];
    assign f_out   = fifo_dout[FIELDS_W-1:0];

    assign out_opcode       = f_out.opcode;
    assign out_rd           = f_out.rd;
    assign out_rs1          = f_out.rs1;
    assign out_rs2          = f_out.rs2;
    assign out_funct3       = f_out.funct3;
    assign out_funct7       = f_out.funct7;
    assign out_funct12      = f_out.funct12;
    assign out_decode_error = f_out.decode_error;
    assign out_is_ecall     = f_out.is_ecall;
    assign out_is_ebreak    = f_out.is_ebreak;
    assign out_is_csr       = f_out.is_csr;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: two instances (Zicsr on / off, XLEN=32) share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_rv_decode_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;

    logic        ready_a, valid_a, err_a, ecall_a, ebreak_a, csr_a;
    logic [31:0] pc_a, imm_a;
    logic [6:0]  opc_a, f7_a;
    logic [4:0]  rd_a, rs1_a, rs2_a;
    logic [2:0]  f3_a;
    logic [11:0] f12_a;

    logic        ready_b, valid_b, err_b, ecall_b, ebreak_b, csr_b;
    logic [31:0] pc_b, imm_b;
    logic [6:0]  opc_b, f7_b;
    logic [4:0]  rd_b, rs1_b, rs2_b;
    logic [2:0]  f3_b;
    logic [11:0] f12_b;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32), .PC_WIDTH(32), .BUFFER_DEPTH(DEPTH), .ENABLE_ZICSR(1)) u_csr (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ready_a),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(valid_a), .out_ready(out_ready),
        .out_pc(pc_a), .out_opcode(opc_a), .out_rd(rd_a), .out_rs1(rs1_a), .out_rs2(rs2_a),
        .out_funct3(f3_a), .out_funct7(f7_a), .out_funct12(f12_a), .out_imm(imm_a),
        .out_decode_error(err_a), .out_is_ecall(ecall_a), .out_is_ebreak(ebreak_a),
        .out_is_csr(csr_a)
    );

    rv_decode_stage #(.XLEN(32), .PC_WIDTH(32), .BUFFER_DEPTH(DEPTH), .ENABLE_ZICSR(0)) u_nocsr (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ready_b),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(valid_b), .out_ready(out_ready),
        .out_pc(pc_b), .out_opcode(opc_b), .out_rd(rd_b), .out_rs1(rs1_b), .out_rs2(rs2_b),
        .out_funct3(f3_b), .out_funct7(f7_b), .out_funct12(f12_b), .out_imm(imm_b),
        .out_decode_error(err_b), .out_is_ecall(ecall_b), .out_is_ebreak(ebreak_b),
        .out_is_csr(csr_b)
    );

    wire [111:0] obs_a = {pc_a, opc_a, rd_a, rs1_a, rs2_a, f3_a, f7_a, f12_a, imm_a,
                          err_a, ecall_a, ebreak_a, csr_a};
    wire [111:0] obs_b = {pc_b, opc_b, rd_b, rs1_b, rs2_b, f3_b, f7_b, f12_b, imm_b,
                          err_b, ecall_b, ebreak_b, csr_b};

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } beat_t;

    beat_t mq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected decoded entry for an RV32 instruction, straight from the ISA rules.
    function automatic logic [111:0] exp_vec(input beat_t b, input bit zicsr);
        logic [31:0] i;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        bit          err, ecall, ebreak, csr;
        i   = b.inst;
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        case (opc)
            7'h33: err = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            7'h13: err = (f3 == 3'd1 && f7 != 7'h00) ||
                         (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            7'h03: err = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            7'h23: err = (f3 > 3'd2);
            7'h63: err = (f3 == 3'd2 || f3 == 3'd3);
            7'h67: err = (f3 != 3'd0);
            7'h37, 7'h17, 7'h6F, 7'h0F: err = 1'b0;
            7'h73: begin
                if (f3 == 3'd0)      err = !(i == 32'h0000_0073 || i == 32'h0010_0073);
                else if (f3 == 3'd4) err = 1'b1;
                else                 err = !zicsr;
            end
            default: err = 1'b1;
        endcase
        ecall  = (i == 32'h0000_0073);
        ebreak = (i == 32'h0010_0073);
        csr    = !err && opc == 7'h73 && f3 != 3'd0 && f3 != 3'd4;
        case (opc)
            7'h23:        imm = {{20{i[31]}}, i[31:25], i[11:7]};
            7'h37, 7'h17: imm = {i[31:12], 12'h000};
            7'h6F:        imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            7'h63:        imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default:      imm = {{20{i[31]}}, i[31:20]};
        endcase
        return {b.pc, opc, i[11:7], i[19:15], i[24:20], f3, f7, i[31:20], imm,
                err, ecall, ebreak, csr};
    endfunction

    // Reference queue: rst clears, flush clears and drops the input beat, else pop then push.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            bit    pop, push;
            beat_t b;
            pop  = (mq.size() > 0) && out_ready;
            push = in_valid && (mq.size() < DEPTH) && !flush;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    b.inst = in_inst;
                    b.pc   = in_pc;
                    mq.push_back(b);
                end
            end
        end
    end

    // Per-cycle compare of both instances against the reference queue.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("A.out_valid", valid_a, mq.size() > 0);
            chk("B.out_valid", valid_b, mq.size() > 0);
            chk("A.in_ready", ready_a, mq.size() < DEPTH);
            chk("B.in_ready", ready_b, mq.size() < DEPTH);
            if (mq.size() > 0) begin
                chk("A.entry", obs_a, exp_vec(mq[0], 1'b1));
                chk("B.entry", obs_b, exp_vec(mq[0], 1'b0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        logic [6:0]  opcs [13];
        int          k;
        opcs = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k >= 13) return r;
        r[6:0] = opcs[k];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        if (opcs[k] == 7'h73) begin
            case ($urandom_range(0, 3))
                0: r = 32'h0000_0073;
                1: r = 32'h0010_0073;
                2: begin
                    r[31:20] = {11'b0, r[20]};
                    r[19:15] = 5'd0;
                    r[11:7]  = 5'd0;
                end
                default: ;
            endcase
        end
        return r;
    endfunction

    logic [31:0] seq_inst [3];
    logic [31:0] seq_imm  [3];
    logic [31:0] sys_inst [4];
    logic [31:0] rpc;

    initial begin
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        chk("rst.out_valid", valid_a, 1'b0);
        chk("rst.in_ready", ready_a, 1'b1);
        chk("rst.data_a", obs_a, 112'd0);
        chk("rst.data_b", obs_b, 112'd0);

        // addi x1,x0,-1 with 1-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF0_0093;
        in_pc     = 32'h100;
        step();
        in_valid = 1'b0;
        chk("addi.valid", valid_a, 1'b1);
        chk("addi.rd", rd_a, 5'd1);
        chk("addi.imm", imm_a, 32'hFFFF_FFFF);
        chk("addi.err", err_a, 1'b0);
        step();

        // U / J / B immediates in order
        seq_inst = '{32'h1234_52B7, 32'hFFDF_F06F, 32'h0000_0463};
        seq_imm  = '{32'h1234_5000, 32'hFFFF_FFFC, 32'h0000_0008};
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_inst = seq_inst[k];
            in_pc   = 32'h200 + 32'(4 * k);
            step();
            chk("imm.seq", imm_a, seq_imm[k]);
        end
        in_valid = 1'b0;
        step();

        // SYSTEM classification
        sys_inst = '{32'h0000_0073, 32'h0010_0073, 32'h0000_0000, 32'h3000_9073};
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_inst = sys_inst[k];
            in_pc   = 32'h300 + 32'(4 * k);
            step();
            case (k)
                0: chk("sys.ecall", {ecall_a, ebreak_a, err_a}, 3'b100);
                1: chk("sys.ebreak", {ecall_a, ebreak_a, err_a}, 3'b010);
                2: chk("sys.zero_err", {err_a, err_b}, 2'b11);
                default: begin
                    chk("sys.csrrw_nocsr", {err_b, csr_b}, 2'b10);
                    chk("sys.csrrw_csr", {err_a, csr_a}, 2'b01);
                end
            endcase
        end
        in_valid = 1'b0;
        step();

        // Back-pressure: three beats into a two-entry buffer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h0000_0013;
        in_pc     = 32'h0;
        step();
        in_pc = 32'h4;
        step();
        chk("bp.full_ready", ready_a, 1'b0);
        in_pc     = 32'h8;
        out_ready = 1'b1;
        chk("bp.pc0", pc_a, 32'h0);
        step();
        chk("bp.pc4", pc_a, 32'h4);
        chk("bp.ready_again", ready_a, 1'b1);
        step();
        chk("bp.pc8", pc_a, 32'h8);
        in_valid = 1'b0;
        step();
        chk("bp.drained", valid_a, 1'b0);

        // Flush with a full buffer, then flush dropping a beat into an empty one
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h10;
        step();
        in_pc = 32'h14;
        step();
        flush = 1'b1;
        in_pc = 32'h18;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.valid", valid_a, 1'b0);
        chk("flush.ready", ready_a, 1'b1);
        in_valid = 1'b1;
        in_pc    = 32'h1C;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.drop", valid_a, 1'b0);

        // Reset while full, then a fresh beat
        in_valid = 1'b1;
        in_pc    = 32'h20;
        step();
        in_pc = 32'h24;
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        chk("rstfull.valid", valid_a, 1'b0);
        chk("rstfull.ready", ready_a, 1'b1);
        in_valid = 1'b1;
        in_inst  = 32'hFFF0_0093;
        in_pc    = 32'h40;
        step();
        in_valid = 1'b0;
        chk("rstfull.fresh_valid", valid_a, 1'b1);
        chk("rstfull.fresh_pc", pc_a, 32'h40);
        out_ready = 1'b1;
        step();

        // Randomized traffic
        rpc = 32'h1000;
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 199) == 0);
            in_inst   = gen_inst();
            in_pc     = rpc;
            rpc       = rpc + 32'd4;
            step();
        end
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
